// File: rtl/cmp_branch_resolver_pkg.sv
// cmp_branch_resolver shared types
// condition codes, flag indices, helpers
package cmp_branch_resolver_pkg;

  localparam int NFLG = 5;

  localparam int FLG_CF = 0;
  localparam int FLG_PF = 1;
  localparam int FLG_ZF = 2;
  localparam int FLG_SF = 3;
  localparam int FLG_OF = 4;

  typedef logic [NFLG-1:0] flags_t;

  typedef enum logic [3:0] {
    CC_O  = 4'h0,
    CC_NO = 4'h1,
    CC_B  = 4'h2,
    CC_AE = 4'h3,
    CC_E  = 4'h4,
    CC_NE = 4'h5,
    CC_BE = 4'h6,
    CC_A  = 4'h7,
    CC_S  = 4'h8,
    CC_NS = 4'h9,
    CC_P  = 4'hA,
    CC_NP = 4'hB,
    CC_L  = 4'hC,
    CC_GE = 4'hD,
    CC_LE = 4'hE,
    CC_G  = 4'hF
  } cc_e;

  typedef enum logic {
    NO_FLAGS   = 1'b0,
    HAVE_FLAGS = 1'b1
  } fv_state_e;

  // PF is set when the low byte has an even number of ones
  function automatic logic parity8(
    input logic [7:0] v
  );
    return ~^v;
  endfunction

endpackage

// File: rtl/cmp_branch_resolver_if.sv
// cmp_branch_resolver port bundle
// compare, branch and result channels
interface cmp_branch_resolver_if
  import cmp_branch_resolver_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             cmp_valid;
  logic             cmp_ready;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;

  logic             br_valid;
  logic             br_ready;
  logic [3:0]       br_cc;

  logic             res_valid;
  logic             res_ready;
  logic             res_taken;

  flags_t           flags;
  logic             flags_valid;
  logic             bigger;
  logic             equal;
  logic             smallest;

  modport master (
    output cmp_valid,
    output cmp_a,
    output cmp_b,
    output br_valid,
    output br_cc,
    output res_ready,
    input  cmp_ready,
    input  br_ready,
    input  res_valid,
    input  res_taken,
    input  flags,
    input  flags_valid,
    input  bigger,
    input  equal,
    input  smallest
  );

  modport slave (
    input  cmp_valid,
    input  cmp_a,
    input  cmp_b,
    input  br_valid,
    input  br_cc,
    input  res_ready,
    output cmp_ready,
    output br_ready,
    output res_valid,
    output res_taken,
    output flags,
    output flags_valid,
    output bigger,
    output equal,
    output smallest
  );

endinterface

// File: rtl/cmp_branch_resolver_cc_eval.sv
// cc_eval: 8086 Jcc condition evaluator
// pure combinational cc x flags -> taken
module cc_eval
  import cmp_branch_resolver_pkg::*;
(
  input  logic [3:0] cc,
  input  flags_t     flags,
  output logic       taken
);

  logic of_f;
  logic sf_f;
  logic zf_f;
  logic pf_f;
  logic cf_f;
  logic lt_f;

  assign of_f = flags[FLG_OF];
  assign sf_f = flags[FLG_SF];
  assign zf_f = flags[FLG_ZF];
  assign pf_f = flags[FLG_PF];
  assign cf_f = flags[FLG_CF];
  assign lt_f = sf_f ^ of_f;

  // decode the condition against the flags
  always_comb begin
    taken = 1'b0;
    unique case (cc_e'(cc))
      CC_O:  taken = of_f;
      CC_NO: taken = ~of_f;
      CC_B:  taken = cf_f;
      CC_AE: taken = ~cf_f;
      CC_E:  taken = zf_f;
      CC_NE: taken = ~zf_f;
      CC_BE: taken = cf_f | zf_f;
      CC_A:  taken = ~(cf_f | zf_f);
      CC_S:  taken = sf_f;
      CC_NS: taken = ~sf_f;
      CC_P:  taken = pf_f;
      CC_NP: taken = ~pf_f;
      CC_L:  taken = lt_f;
      CC_GE: taken = ~lt_f;
      CC_LE: taken = zf_f | lt_f;
      CC_G:  taken = ~(zf_f | lt_f);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_branch_resolver.sv
// cmp_branch_resolver: CMP flags + Jcc
// flag register and 1-entry result buffer
module cmp_branch_resolver
  import cmp_branch_resolver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cmp_branch_resolver_if.slave bus
);

  logic [WIDTH:0] diff;
  flags_t         cmp_flags;

  flags_t         flags_d;
  flags_t         flags_q;
  fv_state_e      state_d;
  fv_state_e      state_q;
  logic           res_valid_d;
  logic           res_valid_q;
  logic           res_taken_d;
  logic           res_taken_q;

  logic           flags_valid;
  logic           cmp_fire;
  logic           br_ready;
  logic           br_fire;
  logic           eval_taken;

  // subtract with one extra bit for borrow
  always_comb begin
    diff = {1'b0, bus.cmp_a} - {1'b0, bus.cmp_b};
  end

  // flags for the incoming operand pair
  always_comb begin
    cmp_flags         = '0;
    cmp_flags[FLG_CF] = diff[WIDTH];
    cmp_flags[FLG_ZF] = (diff[WIDTH-1:0] == '0);
    cmp_flags[FLG_SF] = diff[WIDTH-1];
    cmp_flags[FLG_OF] =
      (bus.cmp_a[WIDTH-1] != bus.cmp_b[WIDTH-1]) &
      (diff[WIDTH-1] != bus.cmp_a[WIDTH-1]);
    cmp_flags[FLG_PF] = parity8(diff[7:0]);
  end

  assign flags_valid = (state_q == HAVE_FLAGS);
  assign cmp_fire    = bus.cmp_valid;
  assign br_ready    = flags_valid &
                       (~res_valid_q | bus.res_ready);
  assign br_fire     = bus.br_valid & br_ready;

  // branch sees the flags held before this edge
  cc_eval u_cc_eval (
    .cc    (bus.br_cc),
    .flags (flags_q),
    .taken (eval_taken)
  );

  // next-state for flags, fsm and result buffer
  always_comb begin
    flags_d     = flags_q;
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_taken_d = res_taken_q;
    if (cmp_fire) begin
      flags_d = cmp_flags;
      state_d = HAVE_FLAGS;
    end
    if (br_fire) begin
      res_valid_d = 1'b1;
      res_taken_d = eval_taken;
    end else if (res_valid_q & bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // flags-valid fsm; only reset leaves HAVE_FLAGS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NO_FLAGS;
    end else begin
      state_q <= state_d;
    end
  end

  // flag register and result buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      res_taken_q <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      res_taken_q <= res_taken_d;
    end
  end

  assign bus.cmp_ready   = 1'b1;
  assign bus.br_ready    = br_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_taken   = res_taken_q;
  assign bus.flags       = flags_q;
  assign bus.flags_valid = flags_valid;
  assign bus.bigger      = flags_valid &
                           ~flags_q[FLG_CF] &
                           ~flags_q[FLG_ZF];
  assign bus.equal       = flags_valid &
                           flags_q[FLG_ZF];
  assign bus.smallest    = flags_valid &
                           flags_q[FLG_CF];

endmodule

// File: doc/cmp_branch_resolver.md
Name: cmp_branch_resolver

Overview:
- Consumer side of the compare path. Accepts CMP operand pairs, computes and holds 8086-style flags for A minus B in a flag register.
- Resolves Jcc condition requests (8086 4-bit condition codes) against the held flags and returns a registered taken/not-taken result.
- Sits between the ALU compare issue and the branch/fetch logic.

Parameters:
- WIDTH, 8, operand width in bits. PF always uses bits [7:0]; WIDTH must be 8 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmp_valid  input  1  operand pair present.
- cmp_ready  output  1  pair accepted this cycle when both valid and ready are high.
- cmp_a  input  WIDTH  minuend.
- cmp_b  input  WIDTH  subtrahend.
- br_valid  input  1  condition request present.
- br_ready  output  1  request accepted this cycle when both valid and ready are high.
- br_cc  input  4  8086 condition code (Jcc low nibble).
- res_valid  output  1  result held in the output buffer.
- res_ready  input  1  downstream takes the result.
- res_taken  output  1  condition true.
- flags  output  5  {OF,SF,ZF,PF,CF}, current flag register.
- flags_valid  output  1  at least one compare has completed since reset.
- bigger, equal, smallest  output  1 each  unsigned A>B, A==B, A<B, decoded from the held flags.

Behaviour:
- Reset (async, on rst_n low):
  - flags=0, flags_valid=0, res_valid=0, res_taken=0.
  - Outputs are forced while rst_n is low.
  - Any in-flight request is dropped; no result is produced for it.
- cmp_ready is constantly 1. A compare is never stalled.
- Compare fire (cmp_valid & cmp_ready): at that clock edge the flag register loads:
  - diff = {1'b0,A} - {1'b0,B}, computed in WIDTH+1 bits.
  - CF = diff[WIDTH] (borrow).
  - ZF = (diff[WIDTH-1:0]==0).
  - SF = diff[WIDTH-1].
  - OF = (A[WIDTH-1]!=B[WIDTH-1]) & (diff[WIDTH-1]!=A[WIDTH-1]).
  - PF = even parity of diff[7:0], i.e. 1 when the count of ones is even.
  - flags_valid goes to 1.
  - Latency: new flags are visible the cycle after the fire.
- bigger = ~CF & ~ZF; equal = ZF; smallest = CF. All are 0 while flags_valid=0.
- br_ready = flags_valid & (~res_valid | res_ready). One-entry output buffer, with full throughput under continuous res_ready.
- Branch fire (br_valid & br_ready): at that clock edge res_taken loads eval(br_cc, current flags) and res_valid goes to 1. Latency is 1 cycle.
- Condition codes (odd codes are the negation of the preceding even code):
  - 0 O: OF.
  - 1 NO: ~OF.
  - 2 B: CF.
  - 3 AE: ~CF.
  - 4 E: ZF.
  - 5 NE: ~ZF.
  - 6 BE: CF|ZF.
  - 7 A: ~(CF|ZF).
  - 8 S: SF.
  - 9 NS: ~SF.
  - A P: PF.
  - B NP: ~PF.
  - C L: SF^OF.
  - D GE: ~(SF^OF).
  - E LE: ZF|(SF^OF).
  - F G: ~(ZF|(SF^OF)).
- Output buffer:
  - res_valid clears when res_valid & res_ready and no new branch fires in the same cycle.
  - When a result drains and a new branch fires in the same cycle, res_valid stays 1 and res_taken takes the new value.
  - res_taken is held stable while res_valid & ~res_ready.
- Simultaneous compare fire and branch fire: the branch is older in program order. It evaluates the pre-update flags; the compare updates the flags at the same edge.
- Branch while flags_valid=0: br_ready=0, and the request waits. The first compare fire enables br_ready from the next cycle.
- Back-to-back compares: the last one wins. Flags always reflect the most recent fire.
- State: two-state FSM.
  - NO_FLAGS → HAVE_FLAGS on the first compare fire.
  - HAVE_FLAGS is left only by reset.
  - Output buffer state is EMPTY/FULL, tracked by res_valid.

Decomposition:
- Shared package, used by the decoder and the branch unit:
  - Condition-code constants CC_O..CC_G, values 0x0..0xF.
  - Flag bit-index constants FLG_CF=0, FLG_PF=1, FLG_ZF=2, FLG_SF=3, FLG_OF=4.
- One sub-module, cc_eval: combinational 4-bit cc × 5-bit flags → taken. Reused by the future conditional-move path.

Test Plan:
- Unsigned greater: cmp A=0x05, B=0x03.
  - Expect flags CF0 ZF0 SF0 OF0 PF0 and bigger=1.
  - br cc=7 → res_taken=1 one cycle later; cc=6 → 0.
- Borrow case: A=0x03, B=0x05, diff 0xFE.
  - Expect CF1 SF1 OF0 PF0 and smallest=1.
  - cc=2 → 1, cc=C → 1, cc=F → 0.
- Signed overflow: A=0x80, B=0x01, diff 0x7F.
  - Expect CF0 SF0 OF1.
  - cc=0 → 1, cc=C → 1, cc=7 → 1.
- Equal and parity: A=B=0x42.
  - Expect ZF1 PF1 and equal=1.
  - cc=4 → 1, cc=A → 1, cc=F → 0, cc=E → 1.
- Handshake:
  - br_valid held before any compare → br_ready=0.
  - With res_ready=0, a second branch stalls and res_taken stays stable.
  - Same-cycle cmp(0x05,0x03) plus br cc=4 after flags from A=B → res_taken=1 (old flags), then flags read bigger=1.
- Reset mid-operation:
  - Drop rst_n with res_valid=1 → res_valid, flags and flags_valid are 0 immediately, without a clock edge.
  - br_ready stays 0 until the next compare fires.
